// File: rtl/register_dump_controller.sv
// Streams all 32 registers of a dual-read-port register file out over a
// valid/ready interface, two registers per read, in ascending address order.
module register_dump_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rsAddress,
  output logic [4:0]  rtAddress,
  output logic        registerRead,
  input  logic [31:0] readValue0,
  input  logic [31:0] readValue1,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outData,
  output logic [4:0]  outAddress
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    SEND_LO = 3'd2,
    SEND_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  k;
  logic [31:0] buf0;
  logic [31:0] buf1;

  logic last_pair;
  assign last_pair = (k == 4'd15);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = SEND_LO;
      SEND_LO: if (outReady) state_next = SEND_HI;
      SEND_HI: begin
        if (outReady) begin
          state_next = last_pair ? DONE : READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pair counter and capture buffers; buffers are loaded only in READ so a
  // later register file write cannot disturb words waiting to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= 4'd0;
      buf0 <= 32'd0;
      buf1 <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) k <= 4'd0;
        end
        READ: begin
          buf0 <= readValue0;
          buf1 <= readValue1;
        end
        SEND_HI: begin
          if (outReady && !last_pair) k <= k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure functions of state, so they stay stable across stalls.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    rsAddress    = 5'd0;
    rtAddress    = 5'd0;
    registerRead = 1'b0;
    outValid     = 1'b0;
    outData      = 32'd0;
    outAddress   = 5'd0;
    case (state)
      IDLE: ;
      READ: begin
        busy         = 1'b1;
        registerRead = 1'b1;
        rsAddress    = {k, 1'b0};
        rtAddress    = {k, 1'b1};
      end
      SEND_LO: begin
        busy       = 1'b1;
        outValid   = 1'b1;
        outData    = buf0;
        outAddress = {k, 1'b0};
      end
      SEND_HI: begin
        busy       = 1'b1;
        outValid   = 1'b1;
        outData    = buf1;
        outAddress = {k, 1'b1};
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_register_dump_controller.sv
// Bench for register_dump_controller: directed vector table, corner-case
// sequences and randomized dumps against an ascending-dump reference model.
module tb_register_dump_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rs_address;
  logic [4:0]  rt_address;
  logic        register_read;
  logic [31:0] read_value0;
  logic [31:0] read_value1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_address;

  logic [31:0] regs [32];

  int checks   = 0;
  int failures = 0;

  localparam int M_NONE  = 0;
  localparam int M_PULSE = 1;
  localparam int M_MOD   = 2;
  localparam int M_HOLD  = 3;

  register_dump_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rsAddress    (rs_address),
    .rtAddress    (rt_address),
    .registerRead (register_read),
    .readValue0   (read_value0),
    .readValue1   (read_value1),
    .outValid     (out_valid),
    .outReady     (out_ready),
    .outData      (out_data),
    .outAddress   (out_address)
  );

  // Register file model: combinational read, zero when not enabled.
  assign read_value0 = register_read ? regs[rs_address] : 32'd0;
  assign read_value1 = register_read ? regs[rt_address] : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) regs[i] = i * 3;
    regs[12] = 32'd1234;
    regs[5]  = -32'sd555555;
  endtask

  // Reference model: a dump yields words 0..31 in order, each carrying the
  // register value present when the dump began (only later writes differ).
  task automatic run_dump(input int ready_pct, input int mode,
                          input bit exp_timing, input bit exp_const);
    logic [31:0] snap [32];
    logic [31:0] got  [32];
    logic [31:0] hold_data;
    logic [4:0]  hold_addr;
    int n;
    int words;
    bit got_first;
    bit pulsed;
    bit stall;
    for (int i = 0; i < 32; i++) begin
      snap[i] = regs[i];
      got[i]  = 32'd0;
    end
    words = 0; got_first = 0; pulsed = 0; stall = 0;
    hold_data = 32'd0; hold_addr = 5'd0;
    start = 1'b1;
    out_ready = 1'b0;
    step();
    n = 1;
    check("start_to_read", {busy, register_read, rs_address, rt_address},
          {1'b1, 1'b1, 5'd0, 5'd1});
    while (!done && n < 600) begin
      start = (mode == M_HOLD);
      if (stall)
        check("stall_stable", {out_valid, out_address, out_data}, {1'b1, hold_addr, hold_data});
      if (!register_read)
        check("addr_zero_outside_read", {rs_address, rt_address}, 10'd0);
      else
        check("read_exclusive", {out_valid, busy, rt_address}, {1'b0, 1'b1, rs_address | 5'd1});
      if (out_valid && !got_first) begin
        got_first = 1;
        if (exp_timing) check("first_valid_latency", n, 2);
      end
      if (mode == M_PULSE && out_valid && out_address == 5'd14 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (mode == M_MOD && out_valid && out_address == 5'd0) regs[1] = 32'd88;
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        if (words < 32) begin
          check("word_addr", out_address, words);
          check("word_data", out_data, snap[words]);
          got[words] = out_data;
        end else begin
          check("extra_word", words, 31);
        end
        words++;
      end
      stall     = out_valid && !out_ready;
      hold_data = out_data;
      hold_addr = out_address;
      step();
      n++;
    end
    check("done_seen", {done, out_valid}, 2'b10);
    check("word_count", words, 32);
    if (exp_timing) check("dump_cycles", n, 49);
    if (exp_const) begin
      check("word0", got[0], 32'd0);
      check("word5", got[5], 32'hFFF785DD);
      check("word12", got[12], 32'd1234);
    end
    if (mode == M_MOD) check("word1_captured", got[1], 32'd77);
    start = (mode == M_HOLD);
    step();
    check("after_done_idle", {busy, done, out_valid, register_read}, 4'b0000);
    if (mode == M_HOLD) begin
      step();
      check("hold_restart", {busy, register_read, rs_address}, {1'b1, 1'b1, 5'd0});
      start = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        done;
    logic        rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    preload();

    //           rst start rdy  busy vld done rd  rs     rt     addr   data
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd0, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd6};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd0, 32'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};

    for (int i = 0; i < 12; i++) begin
      rst       = vecs[i].rst;
      start     = vecs[i].start;
      out_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d", i),
            {busy, out_valid, done, register_read, rs_address, rt_address, out_address, out_data},
            {vecs[i].busy, vecs[i].valid, vecs[i].done, vecs[i].rd,
             vecs[i].rs, vecs[i].rt, vecs[i].addr, vecs[i].data});
    end
    rst = 1'b0;
    start = 1'b0;

    // Preloaded dump with the sink always ready: latency, length, values.
    run_dump(100, M_NONE, 1, 1);
    // Random back-pressure.
    run_dump(50, M_NONE, 0, 1);
    // Extra start pulse while busy at pair 7.
    run_dump(50, M_PULSE, 0, 1);
    // Register 1 rewritten after its pair was captured.
    regs[1] = 32'd77;
    run_dump(50, M_MOD, 0, 0);
    preload();

    // Reset during SEND_HI of pair 9 aborts without a done pulse.
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (out_valid && out_address == 5'd19) found = 1;
      else step();
    end
    check("reach_send_hi_k9", found, 1'b1);
    rst = 1'b1;
    step();
    check("abort_state", {busy, out_valid, done}, 3'b000);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", {busy, done}, 2'b00);
      step();
    end
    run_dump(100, M_NONE, 1, 1);

    // Start held high: back-to-back dumps through DONE and one IDLE cycle.
    run_dump(100, M_HOLD, 1, 1);

    // Randomized register contents and back-pressure.
    for (int r = 0; r < 4; r++) begin
      regs[0] = 32'd0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      run_dump($urandom_range(90, 30), (r % 2 == 0) ? M_NONE : M_PULSE, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_dump_controller.md
REGISTER_DUMP_CONTROLLER -- requirements
Module: register_dump_controller

Interface
REQ-001 The block SHALL have no parameters; register count 32 and data width 32 are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  dump request; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  one-cycle pulse after last word accepted.
REQ-007 rsAddress  output  5  register file read port 0 address.
REQ-008 rtAddress  output  5  register file read port 1 address.
REQ-009 registerRead  output  1  register file read enable.
REQ-010 readValue0  input  32  register file data for rsAddress; combinational, 0 when registerRead=0.
REQ-011 readValue1  input  32  register file data for rtAddress; combinational, 0 when registerRead=0.
REQ-012 outValid  output  1  outData/outAddress hold a valid word.
REQ-013 outReady  input  1  sink accepts word when outValid and outReady are high at a rising edge.
REQ-014 outData  output  32  dumped register value.
REQ-015 outAddress  output  5  index of register in outData.

Function
REQ-016 States SHALL be IDLE, READ, SEND_LO, SEND_HI, DONE; pair counter k SHALL be 4 bits (0..15).
REQ-017 IDLE: start=1 -> k=0, go READ; start=0 -> stay; all outputs 0.
REQ-018 READ (exactly one cycle): registerRead=1, rsAddress={k,1'b0}, rtAddress={k,1'b1}; at the edge capture readValue0 into buf0, readValue1 into buf1; go SEND_LO.
REQ-019 registerRead SHALL be 1 only in READ; rsAddress/rtAddress SHALL be 0 outside READ.
REQ-020 SEND_LO: outValid=1, outData=buf0, outAddress={k,1'b0}; on outReady go SEND_HI, else hold.
REQ-021 SEND_HI: outValid=1, outData=buf1, outAddress={k,1'b1}; on outReady: k=15 -> DONE, else k=k+1 and go READ; else hold.
REQ-022 outData and outAddress SHALL remain stable while outValid=1 and outReady=0; outValid SHALL NOT drop without acceptance.
REQ-023 DONE: done=1 for exactly one cycle, outValid=0; unconditionally go IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored; start held high through DONE SHALL restart the dump from the IDLE cycle following DONE.
REQ-025 Latency: start high in IDLE at edge N -> outValid first high in cycle N+2 (after READ cycle).
REQ-026 With outReady tied high, a full dump SHALL take 48 cycles from READ entry to DONE entry (3 per pair), done asserted in the following cycle.
REQ-027 Words SHALL be emitted in strictly ascending address order 0..31, each exactly once; register 0 value passed through unmodified (expected 0).
REQ-028 outReady high while outValid=0 SHALL have no effect.
REQ-029 Register file contents changing after a pair is captured SHALL NOT affect buffered words.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, k=0, buf0=buf1=0, all outputs 0, regardless of state.
REQ-031 rst has priority over start; reset mid-dump SHALL abort with no done pulse; next dump restarts at address 0.
REQ-032 After rst deasserts, block SHALL accept start on the first IDLE cycle.

Verification
REQ-033 Preload reg12=1234, reg5=-555555, others=index*3 (reg0 reads 0); start, outReady=1 -> 32 words addr 0..31, word5=32'hFFF785DD, word12=1234, word0=0, done after 48+1 cycles.
REQ-034 outReady random 50% -> same sequence, no dropped/duplicated words, outData/outAddress stable during every stall.
REQ-035 start pulsed again at k=7 while busy -> ignored, single 32-word dump, one done pulse.
REQ-036 rst asserted during SEND_HI of k=9 -> next edge busy=0, outValid=0, no done; new start dumps from address 0.
REQ-037 Modify reg1 from 77 to 88 during SEND_LO of k=0 -> word1 still 77.
REQ-038 start held high continuously -> back-to-back dumps separated by DONE and one IDLE cycle, registerRead never high outside READ.
